fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of decode. It owns the fetch PC (PCF) and the IF/ID pipeline register, and drives a request/ready instruction-memory port that may insert wait states. It obeys stallF/stallD from the hazard unit and redirects on a taken branch resolved in decode (PCsrcD/PCBranchD), squashing the wrong-path fetch.

## Interface
- RESET_PC, 32'h0000_0000, PCF value after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- stallF  in  1  hold PCF / fetch progress (from hazard unit)
- stallD  in  1  hold IF/ID register (from hazard unit)
- PCsrcD  in  1  taken branch in decode; honoured only when ValidD=1 and stallD=0
- PCBranchD  in  32  branch target, sampled with PCsrcD
- imem_req  out  1  instruction read request
- imem_addr  out  32  read address, stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  read completes this cycle; imem_rdata valid same cycle
- imem_rdata  in  32  instruction word
- InstrD  out  32  IF/ID instruction (32'h0 = nop when invalid)
- PCPlus4D  out  32  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction
- fetch_busy  out  1  fetch waiting on memory (FETCH with imem_ready=0, or DRAIN)

## Operation
- Registers: PCF, state, redirect_pc, skid buffer {instr, pc+4}, IF/ID {InstrD, PCPlus4D, ValidD}.
- advance = !stallF && !stallD. redirect = PCsrcD && ValidD && !stallD.
- FETCH: imem_req=1, imem_addr=PCF.
  - redirect: IF/ID <= bubble. If imem_ready: discard rdata, PCF <= PCBranchD, stay FETCH. Else: redirect_pc <= PCBranchD, go DRAIN.
  - else imem_ready && advance: IF/ID <= {imem_rdata, PCF+4, 1}; PCF <= PCF+4.
  - else imem_ready && !advance: skid <= {imem_rdata, PCF+4}; go HOLD; IF/ID held if stallD else bubble.
  - else (!imem_ready): IF/ID <= bubble if !stallD, else held.
- HOLD: imem_req=0.
  - redirect: discard skid, IF/ID <= bubble, PCF <= PCBranchD, go FETCH.
  - advance: IF/ID <= {skid, 1}; PCF <= PCF+4; go FETCH.
  - else IF/ID held if stallD, bubble otherwise.
- DRAIN: imem_req=1, imem_addr=PCF (old address, unchanged). IF/ID bubble unless stallD. On imem_ready: discard rdata, PCF <= redirect_pc, go FETCH. PCsrcD cannot qualify (ValidD=0).
- Bubble = InstrD 32'h0, PCPlus4D 32'h0, ValidD 0.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Redirect has priority over advance and stall-capture in the same cycle.
- Reset (any state, any memory phase): state=FETCH, PCF=RESET_PC, IF/ID bubble, skid and redirect_pc cleared; in-flight read abandoned (memory shares rst).

## Timing
- Reset values: imem_req 0 while rst=1, imem_addr RESET_PC, InstrD 0, PCPlus4D 0, ValidD 0, fetch_busy 0. First request at RESET_PC in the cycle after rst falls.
- Zero-wait memory: word at PCF in cycle N appears on InstrD in N+1; throughput 1 instr/cycle.
- k wait states: k extra bubbles on ValidD; imem_addr constant for k+1 cycles.
- Taken branch: redirect in cycle N; imem_addr=target in N+1; target instruction in IF/ID at N+2 (zero-wait), one bubble.
- HOLD releases the buffered word in the first advance cycle with no new request; next request issued the following cycle.
- imem_req never deasserts while a read is outstanding except under rst.

## Test plan
- Reset, zero-wait memory returning rdata=addr: after rst falls, InstrD = 0,4,8 on consecutive cycles, PCPlus4D = 4,8,12, ValidD=1 throughout.
- imem_ready low 3 cycles at addr 0x8: imem_addr stays 0x8, fetch_busy=1, ValidD=0 for 3 cycles, then InstrD=0x8, PCPlus4D=0xC.
- stallF=stallD=1 for 2 cycles while word 0x10 returns: imem_req=0, IF/ID unchanged; on release InstrD=0x10 with no repeated request to 0x10, next request 0x14.
- PCsrcD=1, ValidD=1, PCBranchD=0x100, zero-wait: next cycle ValidD=0, imem_addr=0x100; following cycle InstrD=0x100, PCPlus4D=0x104.
- PCsrcD (target 0x200) while read at 0x40 waiting 2 cycles: DRAIN, imem_addr held 0x40, response discarded (ValidD stays 0), then request 0x200 and InstrD=0x200.
- rst asserted mid-DRAIN: next cycle all IF/ID outputs 0, redirect dropped, first request after release at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: owns PCF and the IF/ID register, fetching over a req/ready imem port.
// Ports: clk/rst (sync, active-high); stallF/stallD hazard stalls; PCsrcD/PCBranchD
// decode-stage taken branch; imem_req/imem_addr/imem_ready/imem_rdata memory port;
// InstrD/PCPlus4D/ValidD IF/ID outputs; fetch_busy when waiting on memory.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        PCsrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        fetch_busy
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  state_t stateQ, stateNext;
  logic [31:0] pcF, pcNext, redirectPc, skidInstr, skidPc4;
  logic advance, redirect, loadFetch, loadSkid, captureSkid;
  assign advance  = !stallF && !stallD;
  assign redirect = PCsrcD && ValidD && !stallD;
  always_ff @(posedge clk)
    if (rst) stateQ <= FETCH;
    else     stateQ <= stateNext;
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      FETCH:   stateNext = redirect ? (imem_ready ? FETCH : DRAIN)
                                    : ((imem_ready && !advance) ? HOLD : FETCH);
      HOLD:    stateNext = (redirect || advance) ? FETCH : HOLD;
      DRAIN:   stateNext = imem_ready ? FETCH : DRAIN;
      default: stateNext = FETCH;
    endcase
  end
  always_comb begin
    imem_req   = !rst && stateQ != HOLD;
    imem_addr  = pcF;
    fetch_busy = !rst && (stateQ == DRAIN || (stateQ == FETCH && !imem_ready));
  end
  // Redirect outranks both loading IF/ID and capturing into the skid buffer.
  assign loadFetch   = stateQ == FETCH && imem_ready && advance && !redirect;
  assign loadSkid    = stateQ == HOLD && advance && !redirect;
  assign captureSkid = stateQ == FETCH && imem_ready && !advance && !redirect;
  // A redirect that catches the read mid-flight parks its target until DRAIN ends.
  always_comb
    pcNext = (redirect && (stateQ == HOLD || (stateQ == FETCH && imem_ready))) ? PCBranchD
           : (loadFetch || loadSkid)                                         ? pcF + 32'd4
           : (stateQ == DRAIN && imem_ready)                                 ? redirectPc
           :                                                                   pcF;
  always_ff @(posedge clk)
    if (rst) begin
      pcF        <= RESET_PC;
      redirectPc <= '0;
      skidInstr  <= '0;
      skidPc4    <= '0;
      InstrD     <= '0;
      PCPlus4D   <= '0;
      ValidD     <= 1'b0;
    end else begin
      pcF <= pcNext;
      if (stateQ == FETCH && redirect && !imem_ready) redirectPc <= PCBranchD;
      if (captureSkid) begin
        skidInstr <= imem_rdata;
        skidPc4   <= pcF + 32'd4;
      end
      InstrD   <= loadFetch ? imem_rdata  : loadSkid ? skidInstr : stallD ? InstrD   : 32'h0;
      PCPlus4D <= loadFetch ? pcF + 32'd4 : loadSkid ? skidPc4   : stallD ? PCPlus4D : 32'h0;
      ValidD   <= (loadFetch || loadSkid) ? 1'b1 : stallD && ValidD;
    end
endmodule
